// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - decode-side control bundle between the core and the hazard controller
//
// Ports grouped here:
//   decode inputs   : d_valid, d_rs1, d_rs2, d_rd, d_reg_we, d_mem_rr
//   pipeline events : x_redirect, mem_busy
//   control outputs : stall_fd, stall_x, bubble_x, flush_d, fwd_a_sel, fwd_b_sel
//   counters        : stall_count, flush_count (CNT_W bits)
// master = core/decode side, slave = hazard controller.

interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             d_valid;
    logic [4:0]       d_rs1;
    logic [4:0]       d_rs2;
    logic [4:0]       d_rd;
    logic             d_reg_we;
    logic             d_mem_rr;
    logic             x_redirect;
    logic             mem_busy;

    logic             stall_fd;
    logic             stall_x;
    logic             bubble_x;
    logic             flush_d;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output d_valid, d_rs1, d_rs2, d_rd, d_reg_we, d_mem_rr,
        output x_redirect, mem_busy,
        input  stall_fd, stall_x, bubble_x, flush_d,
        input  fwd_a_sel, fwd_b_sel, stall_count, flush_count
    );

    modport slave (
        input  d_valid, d_rs1, d_rs2, d_rd, d_reg_we, d_mem_rr,
        input  x_redirect, mem_busy,
        output stall_fd, stall_x, bubble_x, flush_d,
        output fwd_a_sel, fwd_b_sel, stall_count, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/bubble/flush, forwarding and freeze control for a 3-stage RV32 pipe
//
// Ports:
//   clk : core clock, all state on rising edge
//   rst : asynchronous active-high reset
//   hz  : pipe_hazard_ctrl_if.slave (decode inputs, redirect/busy, controls, counters)
//
// Shadows {valid, rd, reg_we, mem_rr} of the X and W stages. All controls are
// combinational from that shadow state and the current decode inputs.

module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    pipe_hazard_ctrl_if.slave       hz
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_we;
        logic       mem_rr;
    } shadow_t;

    localparam shadow_t SHADOW_EMPTY = '{valid: 1'b0, rd: 5'd0, reg_we: 1'b0, mem_rr: 1'b0};

    shadow_t          x_q, w_q;
    shadow_t          x_d, w_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic             lu;
    logic             stall_fd;
    logic             stall_x;
    logic             bubble_x;
    logic             flush_d;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    // x0 is hardwired, so a write to it never creates a dependency.
    function automatic logic writes_reg(input shadow_t e, input logic [4:0] r);
        return e.valid & e.reg_we & (e.rd == r) & (r != 5'd0);
    endfunction

    // A load in X has no data yet; select the regfile and let the lu stall
    // hold D until the load reaches W, where it forwards from writeback.
    function automatic logic [1:0] fwd_select(input shadow_t x, input shadow_t w,
                                              input logic [4:0] r);
        if (writes_reg(x, r)) begin
            return x.mem_rr ? 2'b00 : 2'b01;
        end else if (writes_reg(w, r)) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    always_comb begin
        stall_fd = 1'b0;
        stall_x  = 1'b0;
        bubble_x = 1'b0;
        flush_d  = 1'b0;
        x_d      = SHADOW_EMPTY;
        w_d      = x_q;

        lu = hz.d_valid & x_q.mem_rr &
             (writes_reg(x_q, hz.d_rs1) | writes_reg(x_q, hz.d_rs2));

        fwd_a = fwd_select(x_q, w_q, hz.d_rs1);
        fwd_b = fwd_select(x_q, w_q, hz.d_rs2);

        if (hz.mem_busy) begin
            // Whole pipe frozen; a pending redirect stays asserted and is
            // acted on in the first non-busy cycle.
            stall_fd = 1'b1;
            stall_x  = 1'b1;
            x_d      = x_q;
            w_d      = w_q;
        end else if (hz.x_redirect) begin
            // D holds a wrong-path instruction, so any lu it raises is moot.
            flush_d  = 1'b1;
            bubble_x = 1'b1;
        end else if (lu) begin
            stall_fd = 1'b1;
            bubble_x = 1'b1;
        end else begin
            x_d = '{valid: hz.d_valid, rd: hz.d_rd, reg_we: hz.d_reg_we, mem_rr: hz.d_mem_rr};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= SHADOW_EMPTY;
            w_q         <= SHADOW_EMPTY;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            x_q         <= x_d;
            w_q         <= w_d;
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, stall_fd};
            flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, flush_d};
        end
    end

    // Outputs are forced low for the whole reset interval, independent of inputs.
    assign hz.stall_fd    = stall_fd & ~rst;
    assign hz.stall_x     = stall_x  & ~rst;
    assign hz.bubble_x    = bubble_x & ~rst;
    assign hz.flush_d     = flush_d  & ~rst;
    assign hz.fwd_a_sel   = rst ? 2'b00 : fwd_a;
    assign hz.fwd_b_sel   = rst ? 2'b00 : fwd_b;
    assign hz.stall_count = stall_cnt_q;
    assign hz.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  ctl;   // {stall_fd, stall_x, bubble_x, flush_d}
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input string field,
                       input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s.%s actual=%0h expected=%0h", nm, field, act, expv);
        end
    endtask

    // Drive one cycle of stimulus shortly after the rising edge and queue
    // the hand-computed response for that cycle.
    task automatic step(input string nm, input logic r, input logic dv,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic we, input logic mr, input logic rdr, input logic bsy,
                        input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                        input int sc, input int fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        hz.d_valid    = dv;
        hz.d_rs1      = rs1;
        hz.d_rs2      = rs2;
        hz.d_rd       = rd;
        hz.d_reg_we   = we;
        hz.d_mem_rr   = mr;
        hz.x_redirect = rdr;
        hz.mem_busy   = bsy;
        e.name = nm;
        e.ctl  = ctl;
        e.fa   = fa;
        e.fb   = fb;
        e.sc   = sc;
        e.fc   = fc;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle; sample on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "stall_fd",    32'(hz.stall_fd),  32'(e.ctl[3]));
                chk(e.name, "stall_x",     32'(hz.stall_x),   32'(e.ctl[2]));
                chk(e.name, "bubble_x",    32'(hz.bubble_x),  32'(e.ctl[1]));
                chk(e.name, "flush_d",     32'(hz.flush_d),   32'(e.ctl[0]));
                chk(e.name, "fwd_a_sel",   32'(hz.fwd_a_sel), 32'(e.fa));
                chk(e.name, "fwd_b_sel",   32'(hz.fwd_b_sel), 32'(e.fb));
                chk(e.name, "stall_count", hz.stall_count,    e.sc);
                chk(e.name, "flush_count", hz.flush_count,    e.fc);
            end
        end
    end

    initial begin
        hz.d_valid    = 1'b0;
        hz.d_rs1      = 5'd0;
        hz.d_rs2      = 5'd0;
        hz.d_rd       = 5'd0;
        hz.d_reg_we   = 1'b0;
        hz.d_mem_rr   = 1'b0;
        hz.x_redirect = 1'b0;
        hz.mem_busy   = 1'b0;

        //    name               rst dv rs1 rs2 rd  we mr rdr bsy ctl      fa     fb     sc fc
        step("rst_hold",         1, 1,  5,  5,  1, 1, 1, 1,  1,  4'b0000, 2'b00, 2'b00, 0, 0);
        step("alu_add_x5",       0, 1,  1,  2,  5, 1, 0, 0,  0,  4'b0000, 2'b00, 2'b00, 0, 0);
        step("sub_fwd_x",        0, 1,  5,  1,  6, 1, 0, 0,  0,  4'b0000, 2'b01, 2'b00, 0, 0);
        step("third_fwd_w",      0, 1,  5,  6, 10, 1, 0, 0,  0,  4'b0000, 2'b10, 2'b01, 0, 0);
        step("lw_x7",            0, 1,  2,  0,  7, 1, 1, 0,  0,  4'b0000, 2'b00, 2'b00, 0, 0);
        step("lu_stall",         0, 1,  7,  7,  8, 1, 0, 0,  0,  4'b1010, 2'b00, 2'b00, 0, 0);
        step("lu_after",         0, 1,  7,  7,  8, 1, 0, 0,  0,  4'b0000, 2'b10, 2'b10, 1, 0);
        step("addi_x0",          0, 1,  0,  0,  0, 1, 0, 0,  0,  4'b0000, 2'b00, 2'b00, 1, 0);
        step("read_x0",          0, 1,  0,  0,  9, 1, 0, 0,  0,  4'b0000, 2'b00, 2'b00, 1, 0);
        step("lw_x11",           0, 1,  1,  2, 11, 1, 1, 0,  0,  4'b0000, 2'b00, 2'b00, 1, 0);
        step("redir_over_lu",    0, 1, 11,  9, 12, 1, 0, 1,  0,  4'b0011, 2'b00, 2'b10, 1, 0);
        step("after_flush",      0, 0,  0,  0,  0, 0, 0, 0,  0,  4'b0000, 2'b00, 2'b00, 1, 1);
        step("lw_x13",           0, 1,  3,  0, 13, 1, 1, 0,  0,  4'b0000, 2'b00, 2'b00, 1, 1);
        step("freeze1",          0, 1, 13,  1, 14, 1, 0, 0,  1,  4'b1100, 2'b00, 2'b00, 1, 1);
        step("freeze2",          0, 1, 13,  1, 14, 1, 0, 0,  1,  4'b1100, 2'b00, 2'b00, 2, 1);
        step("freeze3",          0, 1, 13,  1, 14, 1, 0, 0,  1,  4'b1100, 2'b00, 2'b00, 3, 1);
        step("lu_after_freeze",  0, 1, 13,  1, 14, 1, 0, 0,  0,  4'b1010, 2'b00, 2'b00, 4, 1);
        step("fwd_after_freeze", 0, 1, 13,  1, 14, 1, 0, 0,  0,  4'b0000, 2'b10, 2'b00, 5, 1);
        step("redir_busy",       0, 1, 14,  0, 15, 1, 0, 1,  1,  4'b1100, 2'b01, 2'b00, 5, 1);
        step("redir_release",    0, 1, 14,  0, 15, 1, 0, 1,  0,  4'b0011, 2'b01, 2'b00, 6, 1);
        step("lw_x16",           0, 1, 14,  0, 16, 1, 1, 0,  0,  4'b0000, 2'b10, 2'b00, 6, 2);
        step("rst_mid_lu",       1, 1, 16, 16, 17, 1, 0, 0,  0,  4'b0000, 2'b00, 2'b00, 0, 0);
        step("post_rst_dep",     0, 1, 16, 16, 17, 1, 0, 0,  0,  4'b0000, 2'b00, 2'b00, 0, 0);
        step("post_rst_fwd",     0, 1, 17,  0, 18, 1, 0, 0,  0,  4'b0000, 2'b01, 2'b00, 0, 0);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard controller for the 3-stage RV32 core (D = decode/regread, X = execute/mem-request, W = mem-return/writeback). It shadows the destination-register state of the X and W stages from the decode-stage control signals and produces four things each cycle:

- stall, bubble and flush controls;
- operand-forwarding selects;
- a full-pipeline freeze while data memory is busy;
- two performance counters.

It sits beside the decode block and drives the PC/D enables and the X-stage input mux.

## Interface
Parameters:
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- d_valid  in  1  D stage holds a real instruction
- d_rs1, d_rs2  in  5  source registers of D instruction
- d_rd  in  5  destination register of D instruction
- d_reg_we  in  1  D instruction writes rd
- d_mem_rr  in  1  D instruction is a load
- x_redirect  in  1  X instruction is a taken branch/jump; PC redirected this cycle
- mem_busy  in  1  data memory cannot complete this cycle
- stall_fd  out  1  hold PC and D pipeline register
- stall_x  out  1  hold X and W pipeline registers
- bubble_x  out  1  load a NOP into X instead of D instruction
- flush_d  out  1  squash instruction in D (wrong path)
- fwd_a_sel, fwd_b_sel  out  2  operand source for rs1/rs2: 00 regfile, 01 X ALU result, 10 W writeback value
- stall_count  out  CNT_W  cycles with stall_fd=1
- flush_count  out  CNT_W  cycles with flush_d=1

## Operation
- **State:**
  - Two shadow entries, X and W, each holding {valid, rd, reg_we, mem_rr}.
  - Two counters.
  - An X entry "writes r" when valid & reg_we & rd==r & r!=0. Same definition for W.
- **Load-use hazard (lu):** d_valid & the X entry is a load (mem_rr) & it writes d_rs1 or d_rs2.
- **Priority, evaluated each cycle:**
  1. **mem_busy=1:**
     - stall_fd=1, stall_x=1.
     - bubble_x=0, flush_d=0.
     - X and W entries unchanged.
  2. **x_redirect=1:**
     - flush_d=1, bubble_x=1.
     - X←invalid, W←X.
     - lu is ignored, because the D instruction is wrong-path.
  3. **lu=1:**
     - stall_fd=1, bubble_x=1.
     - X←invalid, W←X.
  4. **Otherwise:**
     - X←{d_valid, d_rd, d_reg_we, d_mem_rr}, W←X.
- **Forwarding, per operand r (rs1 or rs2):**
  - 01 if the X entry writes r and X is not a load.
  - Else 10 if the W entry writes r.
  - Else 00.
  - X has priority over W.
  - Register x0 always selects 00.
  - When the X entry is a load that writes r, the select is 00; the lu stall covers this case.
  - The selects are valid whenever d_valid=1. They are driven identically during freeze.
- **Counters:**
  - Increment by 1 on each cycle the corresponding output is 1.
  - They wrap modulo 2^CNT_W; no saturation.
  - Freeze cycles count as stall cycles.

## Timing
- All control outputs are combinational from the current shadow state plus same-cycle inputs: zero-cycle latency to the datapath enables.
- Shadow entries and counters update on the rising clk edge.
- A load-use stall lasts exactly one cycle. On the next cycle the load is in W, lu=0, and the operand forwards 10.
- A redirect asserted in the same cycle as lu: treat as redirect only. No stall, and flush_count increments.
- A redirect asserted during mem_busy: ignored for that cycle, with all state frozen. The X stage holds, so x_redirect stays high and takes effect in the first non-busy cycle.
- **Reset behaviour:**
  - While rst=1: X/W entries invalid and counters 0.
  - All outputs 0, regardless of other inputs.
  - Deassertion takes effect at the next edge; the first post-reset cycle follows the normal rules.
  - Reset mid-stall or mid-freeze discards all shadow state immediately (asynchronous).

## Test plan
1. **Back-to-back ALU:** `add x5` in D, then `sub x6,x5,x1` in D next cycle.
   - fwd_a_sel=01, stall_fd=0.
   - A third instruction reading x5 gets 10.
2. **Load-use:** `lw x7` followed by `add x8,x7,x7`.
   - One cycle with stall_fd=1, bubble_x=1.
   - Next cycle fwd_a_sel=fwd_b_sel=10, stall_count=1.
3. **x0 write:** `addi x0,x0,1` followed by `add x9,x0,x0`.
   - fwd selects 00, no stall.
4. **Redirect vs. load-use:** x_redirect=1 while D holds a load-use dependent.
   - flush_d=1, bubble_x=1, stall_fd=0.
   - flush_count=1, stall_count unchanged.
5. **Memory freeze:** mem_busy=1 for 3 cycles with a lw in X and a dependent in D.
   - stall_fd=stall_x=1 for 3 cycles, no bubble, entries unchanged.
   - Then a 1-cycle lu stall follows; stall_count=4.
6. **Async reset:** assert rst mid lu stall, between clock edges.
   - All outputs 0 immediately.
   - Counters 0.
   - After release, a dependent add receives 00.
